// File: rtl/clint_pkg.sv
// Shared constants and types for the core-local interruptor (register offsets,
// bus FSM states, decoded-register selector, per-hart register struct).
package clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF = MTIME_OFF + 16'd4;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    DONE
  } clint_state_t;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_MTIME_LO,
    REG_MTIME_HI
  } clint_reg_t;

  typedef struct packed {
    clint_reg_t  sel;
    logic [2:0]  hart;
  } clint_dec_t;

  typedef struct packed {
    logic [63:0] mtimecmp;
    logic        msip;
  } clint_hart_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_timer_unit_if.sv
// Generic-bus connection between a system-bus master and the interruptor.
interface clint_timer_unit_if;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        busy;
  logic        error;

  modport master (
    output ren, wen, addr, wdata, byte_en,
    input  rdata, busy, error
  );

  modport slave (
    input  ren, wen, addr, wdata, byte_en,
    output rdata, busy, error
  );
endinterface

// File: rtl/mtime_counter.sv
// 64-bit mtime counter with byte-laned half writes; with CLINT_PRESCALER_EN
// defined it ticks once per PRESCALE clocks, otherwise every clock.
module mtime_counter
  import clint_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [63:0] mtime_o,
  output logic        tick_o
);

  logic [63:0] mtime_q, mtime_d;

`ifdef CLINT_PRESCALER_EN
  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pre_q, pre_d;

  assign tick_o = (pre_q == LAST);

  // A write to mtime restarts the prescale period so the written value is held a full period.
  always_comb begin
    pre_d = tick_o ? '0 : pre_q + 1'b1;
    if (wr_lo_i || wr_hi_i) pre_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pre_q <= '0;
    else       pre_q <= pre_d;
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign tick_o          = 1'b1;
`endif

  // A bus write beats a tick: the untouched half neither increments nor takes a carry.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_lo_i)     mtime_d[31:0]  = merge_bytes(mtime_q[31:0], wdata_i, be_i);
    else if (wr_hi_i) mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdata_i, be_i);
    else if (tick_o) mtime_d        = mtime_q + 64'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mtime_q <= '0;
    else       mtime_q <= mtime_d;
  end

  assign mtime_o = mtime_q;

endmodule

// File: rtl/clint_timer_unit.sv
// Core-local interruptor: bus slave for msip/mtimecmp/mtime, timer and software
// interrupt lines with clear pulses. Optional prescaler: CLINT_PRESCALER_EN.
module clint_timer_unit
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          NUM_HARTS = 3,
  parameter int          PRESCALE  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  clint_timer_unit_if.slave    bus,
  output logic [63:0]          mtime,
  output logic [NUM_HARTS-1:0] timer_int,
  output logic [NUM_HARTS-1:0] timer_int_clear,
  output logic [NUM_HARTS-1:0] soft_int,
  output logic [NUM_HARTS-1:0] soft_int_clear
);

  localparam logic [11:0] MSIP_SLOTS = 12'(NUM_HARTS);
  localparam logic [10:0] CMP_SLOTS  = 11'(NUM_HARTS);

  clint_state_t         state_q, state_d;
  logic                 req, accept, commit, busy;
  clint_dec_t           req_dec, dec_q;
  logic [31:0]          wdata_q;
  logic [3:0]           be_q;
  logic                 wr_q;
  logic [31:0]          rd_val, rdata_q;
  logic                 error_q;
  clint_hart_t          regs_q [NUM_HARTS];
  clint_hart_t          regs_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] cmp_ge, timer_int_q, timer_clr_q, soft_clr_q;
  logic                 mt_wr_lo, mt_wr_hi, mtime_tick_unused;

  function automatic clint_dec_t decode(input logic [31:0] a);
    logic [31:0] off;
    clint_dec_t  d;
    off    = a - BASE_ADDR;
    d.sel  = REG_NONE;
    d.hart = '0;
    if (a[1:0] == 2'b00 && off[31:16] == 16'd0) begin
      if (off[15:14] == MSIP_OFF[15:14] && off[13:2] < MSIP_SLOTS) begin
        d.sel  = REG_MSIP;
        d.hart = off[4:2];
      end else if (off[15:14] == MTIMECMP_OFF[15:14] && off[13:3] < CMP_SLOTS) begin
        d.sel  = off[2] ? REG_CMP_HI : REG_CMP_LO;
        d.hart = off[5:3];
      end else if (off[15:0] == MTIME_OFF) begin
        d.sel = REG_MTIME_LO;
      end else if (off[15:0] == MTIME_HI_OFF) begin
        d.sel = REG_MTIME_HI;
      end
    end
    return d;
  endfunction

  assign req     = bus.ren | bus.wen;
  assign accept  = (state_q == IDLE) && req;
  assign commit  = (state_q == RESP) && wr_q;
  assign req_dec = decode(bus.addr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = RESP;
      RESP:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DONE keeps busy high for one cycle so the master's request drop is not seen as a new access.
  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      IDLE:    busy = req;
      RESP:    busy = 1'b0;
      DONE:    busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      dec_q   <= req_dec;
      wdata_q <= bus.wdata;
      be_q    <= bus.byte_en;
    end
  end

  always_comb begin
    rd_val = '0;
    case (req_dec.sel)
      REG_MTIME_LO: rd_val = mtime[31:0];
      REG_MTIME_HI: rd_val = mtime[63:32];
      default:      ;
    endcase
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (req_dec.hart == 3'(h)) begin
        case (req_dec.sel)
          REG_MSIP:   rd_val = {31'd0, regs_q[h].msip};
          REG_CMP_LO: rd_val = regs_q[h].mtimecmp[31:0];
          REG_CMP_HI: rd_val = regs_q[h].mtimecmp[63:32];
          default:    ;
        endcase
      end
    end
  end

  // Response registers hold their value only during RESP; both wen and ren count as a write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_q    <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (accept) wr_q <= bus.wen;
      rdata_q <= (accept && !bus.wen) ? rd_val : '0;
      error_q <= accept && (req_dec.sel == REG_NONE);
    end
  end

  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      regs_d[h] = regs_q[h];
      if (commit && dec_q.hart == 3'(h)) begin
        case (dec_q.sel)
          REG_MSIP:   if (be_q[0]) regs_d[h].msip = wdata_q[0];
          REG_CMP_LO: regs_d[h].mtimecmp[31:0] =
                        merge_bytes(regs_q[h].mtimecmp[31:0], wdata_q, be_q);
          REG_CMP_HI: regs_d[h].mtimecmp[63:32] =
                        merge_bytes(regs_q[h].mtimecmp[63:32], wdata_q, be_q);
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        regs_q[h].mtimecmp <= '1;
        regs_q[h].msip     <= 1'b0;
      end
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) regs_q[h] <= regs_d[h];
    end
  end

  assign mt_wr_lo = commit && (dec_q.sel == REG_MTIME_LO);
  assign mt_wr_hi = commit && (dec_q.sel == REG_MTIME_HI);

  mtime_counter #(
    .PRESCALE (PRESCALE)
  ) u_mtime (
    .clk_i   (CLK),
    .rst_i   (RST),
    .wr_lo_i (mt_wr_lo),
    .wr_hi_i (mt_wr_hi),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .mtime_o (mtime),
    .tick_o  (mtime_tick_unused)
  );

  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      cmp_ge[h]   = mtime >= regs_q[h].mtimecmp;
      soft_int[h] = regs_q[h].msip;
    end
  end

  // Compare is taken on the current register values, so timer_int lags them by one cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer_int_q <= '0;
      timer_clr_q <= '0;
      soft_clr_q  <= '0;
    end else begin
      timer_int_q <= cmp_ge;
      timer_clr_q <= timer_int_q & ~cmp_ge;
      for (int h = 0; h < NUM_HARTS; h++) soft_clr_q[h] <= regs_q[h].msip & ~regs_d[h].msip;
    end
  end

  assign timer_int       = timer_int_q;
  assign timer_int_clear = timer_clr_q;
  assign soft_int_clear  = soft_clr_q;
  assign bus.busy        = busy;
  assign bus.rdata       = rdata_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_clint_timer_unit.sv
// Self-checking bench for clint_timer_unit: directed scenarios plus random bus
// traffic, all outputs compared each cycle against a transaction-level model.
module tb_clint_timer_unit;

  localparam logic [31:0] BASE  = 32'h0200_0000;
  localparam int          NH    = 3;
  localparam int          PRESC = 16;

  logic          CLK, RST;
  logic [63:0]   mtime;
  logic [NH-1:0] timer_int, timer_int_clear, soft_int, soft_int_clear;

  clint_timer_unit_if bus_if ();

  clint_timer_unit #(
    .BASE_ADDR (BASE),
    .NUM_HARTS (NH),
    .PRESCALE  (PRESC)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .bus             (bus_if.slave),
    .mtime           (mtime),
    .timer_int       (timer_int),
    .timer_int_clear (timer_int_clear),
    .soft_int        (soft_int),
    .soft_int_clear  (soft_int_clear)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  bit tb_done  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: register file as plain values; a pending write is
  // posted by the bus task during the response cycle and lands on the next edge.
  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip, m_tint, m_tclr, m_sclr;
  int            m_pre;
  bit            pw;
  int            pk, ph;
  logic [31:0]   pwd;
  logic [3:0]    pbe;
  logic          m_tick;

`ifdef CLINT_PRESCALER_EN
  assign m_tick = (m_pre == PRESC - 1);
`else
  assign m_tick = 1'b1;
`endif

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  // kind: 0 unmapped, 1 msip, 2 cmp lo, 3 cmp hi, 4 mtime lo, 5 mtime hi
  function automatic void bdec(input logic [31:0] a, output int k, output int h);
    longint off;
    off = longint'(a) - longint'(BASE);
    k = 0;
    h = 0;
    if (a[1:0] != 2'b00 || off < 0 || off >= 65536) return;
    if (off < 4 * NH) begin
      k = 1; h = int'(off / 4);
    end else if (off >= 16384 && off < 16384 + 8 * NH) begin
      h = int'((off - 16384) / 8);
      k = ((off % 8) == 0) ? 2 : 3;
    end else if (off == 49144) k = 4;
    else if (off == 49148) k = 5;
  endfunction

  function automatic logic [31:0] model_read(input int k, input int h);
    case (k)
      1: return {31'd0, m_msip[h]};
      2: return m_cmp[h][31:0];
      3: return m_cmp[h][63:32];
      4: return m_mtime[31:0];
      5: return m_mtime[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ge(input int h);
    return m_mtime >= m_cmp[h];
  endfunction

  function automatic logic msip_after(input int h);
    if (pw && pk == 1 && ph == h && pbe[0]) return pwd[0];
    return m_msip[h];
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_mtime <= '0;
      m_pre   <= 0;
      m_msip  <= '0;
      m_tint  <= '0;
      m_tclr  <= '0;
      m_sclr  <= '0;
      for (int h = 0; h < NH; h++) m_cmp[h] <= '1;
    end else begin
      if (pw && pk == 4)      m_mtime <= {m_mtime[63:32], bmerge(m_mtime[31:0], pwd, pbe)};
      else if (pw && pk == 5) m_mtime <= {bmerge(m_mtime[63:32], pwd, pbe), m_mtime[31:0]};
      else if (m_tick)        m_mtime <= m_mtime + 64'd1;
      if (pw && (pk == 4 || pk == 5)) m_pre <= 0;
      else if (m_tick)                m_pre <= 0;
      else                            m_pre <= m_pre + 1;
      for (int h = 0; h < NH; h++) begin
        m_tint[h] <= ge(h);
        m_tclr[h] <= m_tint[h] & ~ge(h);
        m_sclr[h] <= m_msip[h] & ~msip_after(h);
        m_msip[h] <= msip_after(h);
      end
      if (pw && pk == 2) m_cmp[ph][31:0]  <= bmerge(m_cmp[ph][31:0], pwd, pbe);
      if (pw && pk == 3) m_cmp[ph][63:32] <= bmerge(m_cmp[ph][63:32], pwd, pbe);
    end
  end

  always @(negedge CLK) begin
    if (!RST && !tb_done) begin
      check("mtime", mtime, m_mtime);
      check("timer_int", 64'(timer_int), 64'(m_tint));
      check("timer_int_clear", 64'(timer_int_clear), 64'(m_tclr));
      check("soft_int", 64'(soft_int), 64'(m_msip));
      check("soft_int_clear", 64'(soft_int_clear), 64'(m_sclr));
    end
  end

  // Called on a negedge (cycle N); returns on the negedge of N+3.
  task automatic bus_xfer(input bit ren_v, input bit wen_v, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rd, output logic er);
    int k, h;
    logic [31:0] exp_rd;
    logic exp_er;
    bdec(a, k, h);
    exp_er = (k == 0);
    exp_rd = (wen_v || exp_er) ? 32'd0 : model_read(k, h);
    bus_if.ren     = ren_v;
    bus_if.wen     = wen_v;
    bus_if.addr    = a;
    bus_if.wdata   = wd;
    bus_if.byte_en = be;
    #1;
    check("busy_on_req", 64'(bus_if.busy), 64'd1);
    @(negedge CLK);
    rd = bus_if.rdata;
    er = bus_if.error;
    check("busy_resp", 64'(bus_if.busy), 64'd0);
    check("rdata", 64'(rd), 64'(exp_rd));
    check("error", 64'(er), 64'(exp_er));
    if (wen_v && !exp_er) begin
      pw = 1'b1; pk = k; ph = h; pwd = wd; pbe = be;
    end
    bus_if.ren = 1'b0;
    bus_if.wen = 1'b0;
    @(negedge CLK);
    pw = 1'b0;
    check("busy_done", 64'(bus_if.busy), 64'd1);
    @(negedge CLK);
    check("busy_idle", 64'(bus_if.busy), 64'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  bit          seen;
  logic [31:0] offs [16] = '{32'h0000, 32'h0004, 32'h0008, 32'h000C, 32'h4000, 32'h4004,
                             32'h4008, 32'h400C, 32'h4010, 32'h4014, 32'h4018, 32'hBFF8,
                             32'hBFFC, 32'h0002, 32'h1_0000, 32'h8000};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pw = 1'b0; pk = 0; ph = 0; pwd = '0; pbe = '0;
    bus_if.ren = 1'b0; bus_if.wen = 1'b0; bus_if.addr = '0;
    bus_if.wdata = '0; bus_if.byte_en = '0;
    RST = 1'b0;
    #1 RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    check("rst_rdata", 64'(bus_if.rdata), 64'd0);
    check("rst_error", 64'(bus_if.error), 64'd0);
    check("rst_mtime", mtime, 64'd0);
    check("rst_ints", 64'({timer_int, timer_int_clear, soft_int, soft_int_clear}), 64'd0);
    #2 RST = 1'b0;
    @(negedge CLK);

    bus_xfer(1'b1, 1'b0, BASE + 32'h4000, 32'd0, 4'h0, rd, er);
    check("cmp0_lo_reset", 64'(rd), 64'hFFFF_FFFF);
    check("cmp0_lo_err", 64'(er), 64'd0);

    bus_xfer(1'b0, 1'b1, BASE + 32'h0004, 32'd1, 4'h1, rd, er);
    check("soft1_set", 64'(soft_int[1]), 64'd1);
    bus_xfer(1'b0, 1'b1, BASE + 32'h0004, 32'd0, 4'hF, rd, er);
    check("soft1_clr", 64'(soft_int[1]), 64'd0);
    bus_xfer(1'b0, 1'b1, BASE + 32'h0000, 32'd1, 4'hE, rd, er);
    check("soft0_no_be0", 64'(soft_int[0]), 64'd0);

    bus_xfer(1'b0, 1'b1, BASE + 32'hBFFC, 32'd0, 4'hF, rd, er);
    bus_xfer(1'b0, 1'b1, BASE + 32'hBFF8, 32'd20, 4'hF, rd, er);
    bus_xfer(1'b0, 1'b1, BASE + 32'h4000, 32'd40, 4'hF, rd, er);
    bus_xfer(1'b0, 1'b1, BASE + 32'h4004, 32'd0, 4'hF, rd, er);
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge CLK);
      if (mtime == 64'd40) begin
        seen = 1'b1;
        check("tint_at_40", 64'(timer_int[0]), 64'd0);
        @(negedge CLK);
        check("tint_after_40", 64'(timer_int[0]), 64'd1);
      end
    end
    if (!seen) check("wait_mtime_40", 64'd0, 64'd1);
    bus_xfer(1'b0, 1'b1, BASE + 32'h4004, 32'd1, 4'hF, rd, er);
    check("tint_fell", 64'(timer_int[0]), 64'd0);

    bus_xfer(1'b0, 1'b1, BASE + 32'h4004, 32'hFFFF_FFFF, 4'hF, rd, er);
    bus_xfer(1'b0, 1'b1, BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF, rd, er);
    bus_xfer(1'b0, 1'b1, BASE + 32'hBFFC, 32'd0, 4'hF, rd, er);
    bus_xfer(1'b0, 1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, er);
`ifndef CLINT_PRESCALER_EN
    check("mtime_carry", mtime, 64'h1_0000_0000);
`endif
    bus_xfer(1'b0, 1'b1, BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF, rd, er);
    check("tint_below_max", 64'(timer_int[0]), 64'd0);
    bus_xfer(1'b0, 1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, er);
`ifndef CLINT_PRESCALER_EN
    check("mtime_wrap", mtime, 64'd0);
    check("tint_at_max", 64'(timer_int[0]), 64'd1);
`endif

    bus_xfer(1'b1, 1'b0, BASE + 32'h0002, 32'd0, 4'h0, rd, er);
    check("err_misalign", 64'(er), 64'd1);
    bus_xfer(1'b1, 1'b0, BASE + 32'h401C, 32'd0, 4'h0, rd, er);
    check("err_hart_range", 64'(er), 64'd1);
    bus_xfer(1'b1, 1'b0, BASE + 32'h1_0000, 32'd0, 4'h0, rd, er);
    check("err_window", 64'(er), 64'd1);
    check("err_window_rdata", 64'(rd), 64'd0);
    bus_xfer(1'b0, 1'b1, BASE + 32'h000C, 32'd1, 4'hF, rd, er);
    check("err_write", 64'(er), 64'd1);

    bus_if.ren = 1'b0; bus_if.wen = 1'b1; bus_if.addr = BASE + 32'h4008;
    bus_if.wdata = 32'h1234_5678; bus_if.byte_en = 4'hF;
    @(negedge CLK);
    bus_if.wen = 1'b0;
    RST = 1'b1;
    #1;
    check("rst_mid_busy", 64'(bus_if.busy), 64'd0);
    check("rst_mid_error", 64'(bus_if.error), 64'd0);
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    bus_xfer(1'b1, 1'b0, BASE + 32'h4008, 32'd0, 4'h0, rd, er);
    check("rst_mid_cmp1", 64'(rd), 64'hFFFF_FFFF);

    for (int t = 0; t < 250; t++) begin
      int  idx;
      bit  wr, both;
      idx  = $urandom_range(0, 15);
      wr   = 1'($urandom_range(0, 1));
      both = ($urandom_range(0, 7) == 0);
      bus_xfer(!wr || both, wr || both, BASE + offs[idx], $urandom, 4'($urandom), rd, er);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    tb_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
